// File: rtl/axi_benes_txn_sched.sv
// axi_benes_txn_sched: round-robin scheduler sharing one AXI4 port between two requesters.
// Each job is a write burst of Benes inputs, then a read burst of the permuted outputs.
module axi_benes_txn_sched #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6,
  parameter int ID_WIDTH   = 1
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [15:0]               req_len,
  output logic                      grant_id,
  output logic                      busy,
  input  logic [DATA_WIDTH-1:0]     src_wdata,
  input  logic                      src_wvalid,
  output logic                      src_wready,
  output logic [DATA_WIDTH-1:0]     dst_rdata,
  output logic                      dst_rvalid,
  output logic                      dst_rlast,
  output logic                      done,
  output logic                      err,
  output logic [ID_WIDTH-1:0]       M_AWID,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic                      M_BVALID,
  input  logic [1:0]                M_BRESP,
  output logic                      M_BREADY,
  output logic [ID_WIDTH-1:0]       M_ARID,
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST,
  input  logic                      M_RVALID,
  output logic                      M_RREADY
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t                state_q, state_d;
  logic                  last_q, last_d, id_q, id_d, gnt_q, gnt_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic                  sel, at_last;
  assign sel     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign at_last = cnt_q == len_q;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  // gnt_q marks the accept cycle spent in IDLE, so AW follows req_ready by one cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt_d   = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (gnt_q) state_d = AW;
            else if (|req_valid) begin
              gnt_d  = 1'b1;
              id_d   = sel;
              addr_d = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
              len_d  = sel ? req_len[15:8] : req_len[7:0];
            end
      AW:   if (M_AWREADY) begin
              state_d = W;
              cnt_d   = '0;
            end
      W:    if (src_wvalid && M_WREADY) begin
              cnt_d   = cnt_q + 8'd1;
              state_d = at_last ? B : W;
            end
      B:    if (M_BVALID) begin
              err_d   = err_q | (|M_BRESP);
              state_d = AR;
            end
      AR:   if (M_ARREADY) begin
              state_d = R;
              cnt_d   = '0;
            end
      R:    if (M_RVALID) begin
              err_d   = err_q | (|M_RRESP) | (M_RLAST & ~at_last);
              cnt_d   = cnt_q + 8'd1;
              state_d = at_last ? DONE : R;
            end
      DONE: begin
              last_d  = id_q;
              err_d   = 1'b0;
              state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
  end
  assign busy       = gnt_q | (state_q != IDLE);
  assign grant_id   = busy & id_q;
  assign req_ready  = (state_q == IDLE && gnt_q) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign M_AWID     = '0;
  assign M_ARID     = '0;
  assign M_AWADDR   = addr_q;
  assign M_ARADDR   = addr_q;
  assign M_AWLEN    = len_q;
  assign M_ARLEN    = len_q;
  assign M_AWSIZE   = 3'($clog2(DATA_WIDTH/8));
  assign M_ARSIZE   = 3'($clog2(DATA_WIDTH/8));
  assign M_AWBURST  = 2'b01;
  assign M_ARBURST  = 2'b01;
  assign M_AWVALID  = state_q == AW;
  assign M_WDATA    = src_wdata;
  assign M_WSTRB    = '1;
  assign M_WVALID   = (state_q == W) & src_wvalid;
  assign M_WLAST    = (state_q == W) & at_last;
  assign src_wready = (state_q == W) & M_WREADY;
  assign M_BREADY   = state_q == B;
  assign M_ARVALID  = state_q == AR;
  assign M_RREADY   = state_q == R;
  assign dst_rdata  = M_RDATA;
  assign dst_rvalid = (state_q == R) & M_RVALID;
  assign dst_rlast  = (state_q == R) & at_last;
  assign done       = state_q == DONE;
  assign err        = done & err_q;
endmodule
